// File: rtl/core_wb_arbiter_if.sv
// Bus bundle for the two-requester Wishbone-style arbiter.
// The master modport is the arbiter's own view: it consumes the instruction
// and data requests and drives the single downstream port. The slave modport
// is the mirror image, used by whatever surrounds the arbiter.
interface core_wb_arbiter_if #(
    parameter int ADDRESS_WIDTH = 28
);
    logic [ADDRESS_WIDTH-1:0] instrAddress;
    logic [3:0]               instrByteSelect;
    logic                     instrEnable;
    logic                     instrWriteEnable;
    logic [31:0]              instrDataWrite;
    logic [31:0]              instrDataRead;
    logic                     instrDone;
    logic                     instrBusy;

    logic [ADDRESS_WIDTH-1:0] dataAddress;
    logic [3:0]               dataByteSelect;
    logic                     dataEnable;
    logic                     dataWriteEnable;
    logic [31:0]              dataDataWrite;
    logic [31:0]              dataDataRead;
    logic                     dataDone;
    logic                     dataBusy;

    logic [ADDRESS_WIDTH-1:0] wbAddress;
    logic [3:0]               wbByteSelect;
    logic                     wbEnable;
    logic                     wbWriteEnable;
    logic [31:0]              wbDataWrite;
    logic [31:0]              wbDataRead;
    logic                     wbBusy;

    modport master (
        input  instrAddress, instrByteSelect, instrEnable, instrWriteEnable, instrDataWrite,
        output instrDataRead, instrDone, instrBusy,
        input  dataAddress, dataByteSelect, dataEnable, dataWriteEnable, dataDataWrite,
        output dataDataRead, dataDone, dataBusy,
        output wbAddress, wbByteSelect, wbEnable, wbWriteEnable, wbDataWrite,
        input  wbDataRead, wbBusy
    );

    modport slave (
        output instrAddress, instrByteSelect, instrEnable, instrWriteEnable, instrDataWrite,
        input  instrDataRead, instrDone, instrBusy,
        output dataAddress, dataByteSelect, dataEnable, dataWriteEnable, dataDataWrite,
        input  dataDataRead, dataDone, dataBusy,
        input  wbAddress, wbByteSelect, wbEnable, wbWriteEnable, wbDataWrite,
        output wbDataRead, wbBusy
    );
endinterface

// File: rtl/core_wb_arbiter.sv
// Round-robin arbiter: instruction and data requesters share one downstream
// bus. One transaction at a time: IDLE (grant) -> ISSUE (one cycle) -> WAIT
// (until the downstream stage drops busy). A requester dropping its enable
// mid-transaction aborts it silently. Grant encoding: 0 = instr, 1 = data.
module core_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 28
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    core_wb_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_grant;
    logic                     r_last_grant;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [3:0]               r_bsel;
    logic                     r_we;
    logic [31:0]              r_wdata;
    logic [31:0]              r_instr_rd;
    logic [31:0]              r_data_rd;

    logic                     w_take;
    logic                     w_pick;
    logic                     w_gnt_en;
    logic                     w_done;
    logic                     w_instr_done;
    logic                     w_data_done;

    assign w_gnt_en     = r_grant ? bus.dataEnable : bus.instrEnable;
    assign w_done       = (r_state == S_WAIT) && w_gnt_en && !bus.wbBusy;
    assign w_instr_done = w_done && !r_grant;
    assign w_data_done  = w_done && r_grant;

    // Next-state and grant selection; ties go to the port not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_pick      = r_grant;
        case (r_state)
            S_IDLE: begin
                if (bus.instrEnable || bus.dataEnable) begin
                    w_take      = 1'b1;
                    w_pick      = (bus.instrEnable && bus.dataEnable) ? !r_last_grant
                                                                      : bus.dataEnable;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = w_gnt_en ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!w_gnt_en || !bus.wbBusy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset lands in IDLE, which immediately forces wbEnable low.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winning request's command fields at grant time.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b0;
            r_addr       <= '0;
            r_bsel       <= 4'h0;
            r_we         <= 1'b0;
            r_wdata      <= 32'hFFFF_FFFF;
        end else if (w_take) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_addr       <= w_pick ? bus.dataAddress      : bus.instrAddress;
            r_bsel       <= w_pick ? bus.dataByteSelect   : bus.instrByteSelect;
            r_we         <= w_pick ? bus.dataWriteEnable  : bus.instrWriteEnable;
            r_wdata      <= w_pick ? bus.dataDataWrite    : bus.instrDataWrite;
        end
    end

    // Per-port read holding registers, updated only on that port's completion.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_instr_rd <= 32'hFFFF_FFFF;
            r_data_rd  <= 32'hFFFF_FFFF;
        end else begin
            if (w_instr_done) r_instr_rd <= bus.wbDataRead;
            if (w_data_done)  r_data_rd  <= bus.wbDataRead;
        end
    end

    // wbEnable drops in the completion cycle so the slave does not see a second request.
    assign bus.wbEnable      = w_gnt_en && ((r_state == S_ISSUE) ||
                                            ((r_state == S_WAIT) && bus.wbBusy));
    assign bus.wbAddress     = r_addr;
    assign bus.wbByteSelect  = r_bsel;
    assign bus.wbWriteEnable = r_we;
    assign bus.wbDataWrite   = r_wdata;

    assign bus.instrDone     = w_instr_done;
    assign bus.dataDone      = w_data_done;
    assign bus.instrDataRead = w_instr_done ? bus.wbDataRead : r_instr_rd;
    assign bus.dataDataRead  = w_data_done  ? bus.wbDataRead : r_data_rd;
    assign bus.instrBusy     = bus.instrEnable && !w_instr_done;
    assign bus.dataBusy      = bus.dataEnable  && !w_data_done;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Testbench for core_wb_arbiter: directed scenarios with explicit expectations,
// then a long randomized run against a transaction-level reference model.
module tb_core_wb_arbiter;

    localparam int AW = 28;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    core_wb_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

    core_wb_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.instrAddress = '0; bus.instrByteSelect = 4'h0; bus.instrEnable = 1'b0;
        bus.instrWriteEnable = 1'b0; bus.instrDataWrite = 32'h0;
        bus.dataAddress = '0; bus.dataByteSelect = 4'h0; bus.dataEnable = 1'b0;
        bus.dataWriteEnable = 1'b0; bus.dataDataWrite = 32'h0;
        bus.wbBusy = 1'b0; bus.wbDataRead = 32'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [AW+36:0] fields;
        idle_inputs();
        rst = 1'b1;
        bus.instrEnable = 1'b1;
        bus.dataEnable  = 1'b1;
        bus.wbDataRead  = 32'h0123_4567;
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk);
            vectors++;
            if ({bus.wbEnable, bus.instrDone, bus.dataDone} !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_ctrl got %b want 000", {bus.wbEnable, bus.instrDone, bus.dataDone});
            end
            fields = {bus.wbAddress, bus.wbByteSelect, bus.wbWriteEnable, bus.wbDataWrite};
            vectors++;
            if (fields !== {{AW{1'b0}}, 4'h0, 1'b0, 32'hFFFF_FFFF}) begin
                miscompares++;
                $display("FAIL rst_wb_fields got %h want addr0 bs0 we0 dw ffffffff", fields);
            end
            vectors++;
            if ({bus.instrDataRead, bus.dataDataRead} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                miscompares++;
                $display("FAIL rst_rdregs got %h want ffffffffffffffff",
                         {bus.instrDataRead, bus.dataDataRead});
            end
        end
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        do_reset();
        bus.dataAddress = 28'h000_0100; bus.dataByteSelect = 4'hF; bus.dataEnable = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.wbEnable !== 1'b0) begin
            miscompares++; $display("FAIL sr_c0_wbEnable got %b want 0", bus.wbEnable);
        end
        tick();
        for (int c = 1; c <= 4; c++) begin
            bus.wbBusy = (c == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            vectors++;
            if ({bus.wbEnable, bus.dataDone, bus.wbAddress} !== {1'b1, 1'b0, 28'h000_0100}) begin
                miscompares++;
                $display("FAIL sr_c%0d got en=%b done=%b addr=%h want en=1 done=0 addr=0000100",
                         c, bus.wbEnable, bus.dataDone, bus.wbAddress);
            end
            tick();
        end
        bus.wbBusy = 1'b0; bus.wbDataRead = 32'h1234_5678;
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.dataDone, bus.dataBusy, bus.dataDataRead} !== {3'b010, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL sr_c5 got en=%b done=%b busy=%b rd=%h want en=0 done=1 busy=0 rd=12345678",
                     bus.wbEnable, bus.dataDone, bus.dataBusy, bus.dataDataRead);
        end
        tick();
        bus.dataEnable = 1'b0; bus.wbDataRead = 32'h0;
        @(negedge clk);
        vectors++;
        if ({bus.dataDone, bus.dataDataRead, bus.instrDataRead} !== {1'b0, 32'h1234_5678, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL sr_c6 got done=%b drd=%h ird=%h want done=0 drd=12345678 ird=ffffffff",
                     bus.dataDone, bus.dataDataRead, bus.instrDataRead);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin;
        logic        exp_port;
        logic [31:0] exp_rd [2];
        logic [31:0] rd;
        int          n;
        do_reset();
        exp_port = 1'b1;
        exp_rd[0] = 32'hFFFF_FFFF; exp_rd[1] = 32'hFFFF_FFFF;
        bus.instrAddress = 28'h000_0200; bus.dataAddress = 28'h000_0300;
        bus.instrEnable = 1'b1; bus.dataEnable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            bus.wbBusy = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (bus.wbEnable !== 1'b0) begin
                miscompares++; $display("FAIL rr%0d_idle wbEnable got %b want 0", t, bus.wbEnable);
            end
            tick();
            bus.wbBusy = 1'($urandom);
            @(negedge clk);
            vectors++;
            if ({bus.wbEnable, bus.wbAddress} !== {1'b1, exp_port ? 28'h000_0300 : 28'h000_0200}) begin
                miscompares++;
                $display("FAIL rr%0d_grant got en=%b addr=%h want en=1 port=%s", t, bus.wbEnable,
                         bus.wbAddress, exp_port ? "data" : "instr");
            end
            tick();
            n = $urandom_range(2, 0);
            for (int k = 0; k < n; k++) begin
                bus.wbBusy = 1'b1;
                @(negedge clk);
                vectors++;
                if ({bus.wbEnable, bus.instrDone, bus.dataDone} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL rr%0d_wait got %b want 100", t,
                             {bus.wbEnable, bus.instrDone, bus.dataDone});
                end
                tick();
            end
            rd = $urandom;
            bus.wbBusy = 1'b0; bus.wbDataRead = rd;
            exp_rd[exp_port] = rd;
            @(negedge clk);
            vectors++;
            if ({bus.instrDone, bus.dataDone} !== (exp_port ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL rr%0d_done got idone=%b ddone=%b want port=%s", t, bus.instrDone,
                         bus.dataDone, exp_port ? "data" : "instr");
            end
            vectors++;
            if ({bus.instrDataRead, bus.dataDataRead} !== {exp_rd[0], exp_rd[1]}) begin
                miscompares++;
                $display("FAIL rr%0d_rdata got ird=%h drd=%h want ird=%h drd=%h", t,
                         bus.instrDataRead, bus.dataDataRead, exp_rd[0], exp_rd[1]);
            end
            tick();
            exp_port = !exp_port;
        end
        idle_inputs();
    endtask

    task automatic test_abort;
        do_reset();
        bus.instrEnable = 1'b1; bus.instrAddress = 28'h000_0444;
        tick();
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.wbAddress} !== {1'b1, 28'h000_0444}) begin
            miscompares++;
            $display("FAIL ab_issue got en=%b addr=%h want en=1 addr=0000444", bus.wbEnable, bus.wbAddress);
        end
        tick();
        bus.instrEnable = 1'b0; bus.wbBusy = 1'b1; bus.wbDataRead = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.instrDone, bus.instrBusy} !== 3'b000) begin
            miscompares++;
            $display("FAIL ab_drop got en=%b done=%b busy=%b want 000", bus.wbEnable, bus.instrDone, bus.instrBusy);
        end
        tick();
        bus.dataEnable = 1'b1; bus.dataAddress = 28'h000_0888; bus.wbBusy = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.instrDone, bus.instrDataRead} !== {2'b00, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL ab_idle got en=%b idone=%b ird=%h want en=0 idone=0 ird=ffffffff",
                     bus.wbEnable, bus.instrDone, bus.instrDataRead);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.wbAddress} !== {1'b1, 28'h000_0888}) begin
            miscompares++;
            $display("FAIL ab_regrant got en=%b addr=%h want en=1 addr=0000888", bus.wbEnable, bus.wbAddress);
        end
        tick();
        bus.wbDataRead = 32'h600D_CAFE;
        @(negedge clk);
        vectors++;
        if ({bus.dataDone, bus.instrDataRead, bus.dataDataRead} !== {1'b1, 32'hFFFF_FFFF, 32'h600D_CAFE}) begin
            miscompares++;
            $display("FAIL ab_after got ddone=%b ird=%h drd=%h want ddone=1 ird=ffffffff drd=600dcafe",
                     bus.dataDone, bus.instrDataRead, bus.dataDataRead);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_error_write;
        do_reset();
        bus.dataEnable = 1'b1; bus.dataAddress = 28'h0AB_CDEF;
        tick();
        tick();
        bus.wbDataRead = 32'h1111_2222;
        tick();
        bus.dataWriteEnable = 1'b1; bus.dataByteSelect = 4'h3; bus.dataDataWrite = 32'hCAFE_F00D;
        bus.dataAddress = 28'h055_0000; bus.wbDataRead = 32'h0;
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.dataDone, bus.dataDataRead} !== {2'b00, 32'h1111_2222}) begin
            miscompares++;
            $display("FAIL er_first got en=%b done=%b drd=%h want en=0 done=0 drd=11112222",
                     bus.wbEnable, bus.dataDone, bus.dataDataRead);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.wbWriteEnable, bus.wbByteSelect, bus.wbDataWrite, bus.wbAddress} !==
            {2'b11, 4'h3, 32'hCAFE_F00D, 28'h055_0000}) begin
            miscompares++;
            $display("FAIL er_issue got en=%b we=%b bs=%h dw=%h addr=%h want 1 1 3 cafef00d 0550000",
                     bus.wbEnable, bus.wbWriteEnable, bus.wbByteSelect, bus.wbDataWrite, bus.wbAddress);
        end
        tick();
        bus.wbBusy = 1'b1;
        tick();
        bus.wbBusy = 1'b0; bus.wbDataRead = 32'hFFFF_FFFF;
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.dataDone, bus.dataDataRead} !== {2'b01, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL er_done got en=%b done=%b drd=%h want en=0 done=1 drd=ffffffff",
                     bus.wbEnable, bus.dataDone, bus.dataDataRead);
        end
        tick();
        bus.dataEnable = 1'b0; bus.wbDataRead = 32'h1357_2468;
        @(negedge clk);
        vectors++;
        if ({bus.dataDone, bus.dataDataRead} !== {1'b0, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL er_hold got done=%b drd=%h want done=0 drd=ffffffff", bus.dataDone, bus.dataDataRead);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.dataEnable = 1'b1; bus.dataAddress = 28'h000_1234; bus.dataByteSelect = 4'h5;
        bus.dataDataWrite = 32'h0; bus.wbDataRead = 32'h5A5A_5A5A;
        tick();
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (bus.dataDataRead !== 32'h5A5A_5A5A) begin
            miscompares++; $display("FAIL ar_pre drd got %h want 5a5a5a5a", bus.dataDataRead);
        end
        tick();
        tick();
        bus.wbBusy = 1'b1;
        #1;
        vectors++;
        if (bus.wbEnable !== 1'b1) begin
            miscompares++; $display("FAIL ar_wait wbEnable got %b want 1", bus.wbEnable);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.wbEnable, bus.dataDone, bus.wbAddress, bus.wbByteSelect, bus.wbWriteEnable,
             bus.wbDataWrite, bus.dataDataRead} !==
            {2'b00, {AW{1'b0}}, 4'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL ar_mid got en=%b done=%b addr=%h bs=%h we=%b dw=%h drd=%h want 0 0 0 0 0 ffffffff ffffffff",
                     bus.wbEnable, bus.dataDone, bus.wbAddress, bus.wbByteSelect, bus.wbWriteEnable,
                     bus.wbDataWrite, bus.dataDataRead);
        end
        bus.wbBusy = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.wbEnable, bus.dataDone, bus.instrDone} !== 3'b000) begin
            miscompares++;
            $display("FAIL ar_nodone got %b want 000", {bus.wbEnable, bus.dataDone, bus.instrDone});
        end
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random;
        bit          ie, de, iw, dw, busy;
        logic [AW-1:0] ia, da;
        logic [3:0]  ib, db;
        logic [31:0] id, dd, rdat;
        bit          m_act, m_port, m_first, m_last, m_we;
        logic [AW-1:0] m_addr;
        logic [3:0]  m_bs;
        logic [31:0] m_dw;
        logic [31:0] m_rd [2];
        bit          p_idone, p_ddone, en_g, e_done, e_wbe, e_id, e_dd;
        do_reset();
        m_act = 0; m_port = 0; m_first = 0; m_last = 0; m_we = 0;
        m_addr = '0; m_bs = 4'h0; m_dw = 32'hFFFF_FFFF;
        m_rd[0] = 32'hFFFF_FFFF; m_rd[1] = 32'hFFFF_FFFF;
        ie = 0; de = 0; iw = 0; dw = 0; ia = '0; da = '0; ib = 0; db = 0; id = 0; dd = 0;
        p_idone = 0; p_ddone = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ie) begin
                if ($urandom_range(2, 0) == 0) begin
                    ie = 1; ia = AW'($urandom); ib = 4'($urandom); iw = 1'($urandom); id = $urandom;
                end
            end else if (p_idone) begin
                if ($urandom_range(1, 0) == 0) ie = 0;
                else begin ia = AW'($urandom); ib = 4'($urandom); iw = 1'($urandom); id = $urandom; end
            end else if ($urandom_range(19, 0) == 0) ie = 0;
            else if ($urandom_range(3, 0) == 0) begin ia = AW'($urandom); id = $urandom; end
            if (!de) begin
                if ($urandom_range(2, 0) == 0) begin
                    de = 1; da = AW'($urandom); db = 4'($urandom); dw = 1'($urandom); dd = $urandom;
                end
            end else if (p_ddone) begin
                if ($urandom_range(1, 0) == 0) de = 0;
                else begin da = AW'($urandom); db = 4'($urandom); dw = 1'($urandom); dd = $urandom; end
            end else if ($urandom_range(19, 0) == 0) de = 0;
            else if ($urandom_range(3, 0) == 0) begin da = AW'($urandom); dd = $urandom; end
            busy = 1'($urandom);
            rdat = $urandom;
            bus.instrEnable = ie; bus.instrAddress = ia; bus.instrByteSelect = ib;
            bus.instrWriteEnable = iw; bus.instrDataWrite = id;
            bus.dataEnable = de; bus.dataAddress = da; bus.dataByteSelect = db;
            bus.dataWriteEnable = dw; bus.dataDataWrite = dd;
            bus.wbBusy = busy; bus.wbDataRead = rdat;

            en_g   = m_port ? de : ie;
            e_done = m_act && !m_first && en_g && !busy;
            e_wbe  = m_act && en_g && (m_first || busy);
            e_id   = e_done && !m_port;
            e_dd   = e_done && m_port;

            @(negedge clk);
            vectors++;
            if ({bus.wbEnable, bus.instrDone, bus.dataDone, bus.instrBusy, bus.dataBusy} !==
                {e_wbe, e_id, e_dd, ie && !e_id, de && !e_dd}) begin
                miscompares++;
                $display("FAIL rnd%0d_ctrl got en/idone/ddone/ibusy/dbusy=%b want %b", c,
                         {bus.wbEnable, bus.instrDone, bus.dataDone, bus.instrBusy, bus.dataBusy},
                         {e_wbe, e_id, e_dd, ie && !e_id, de && !e_dd});
            end
            vectors++;
            if ({bus.wbAddress, bus.wbByteSelect, bus.wbWriteEnable, bus.wbDataWrite} !==
                {m_addr, m_bs, m_we, m_dw}) begin
                miscompares++;
                $display("FAIL rnd%0d_cmd got addr=%h bs=%h we=%b dw=%h want addr=%h bs=%h we=%b dw=%h", c,
                         bus.wbAddress, bus.wbByteSelect, bus.wbWriteEnable, bus.wbDataWrite,
                         m_addr, m_bs, m_we, m_dw);
            end
            vectors++;
            if (bus.instrDataRead !== (e_id ? rdat : m_rd[0])) begin
                miscompares++;
                $display("FAIL rnd%0d_ird got %h want %h", c, bus.instrDataRead, e_id ? rdat : m_rd[0]);
            end
            vectors++;
            if (bus.dataDataRead !== (e_dd ? rdat : m_rd[1])) begin
                miscompares++;
                $display("FAIL rnd%0d_drd got %h want %h", c, bus.dataDataRead, e_dd ? rdat : m_rd[1]);
            end

            if (m_act) begin
                if (!en_g || e_done) begin
                    m_act = 0;
                    if (e_done) m_rd[m_port] = rdat;
                end else begin
                    m_first = 0;
                end
            end else if (ie || de) begin
                m_port  = (ie && de) ? !m_last : de;
                m_last  = m_port;
                m_act   = 1;
                m_first = 1;
                m_addr  = m_port ? da : ia;
                m_bs    = m_port ? db : ib;
                m_we    = m_port ? dw : iw;
                m_dw    = m_port ? dd : id;
            end
            p_idone = e_id;
            p_ddone = e_dd;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_abort();
        test_error_write();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_wb_arbiter.md
CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 28, the byte-address width of both requester ports and the downstream port.
REQ-002 SHALL have wb_clk_i  input  1  as the single clock; all state updates on its rising edge.
REQ-003 SHALL have wb_rst_i  input  1  as the reset; reset is asynchronous and active-high.
REQ-004 SHALL provide instruction port:
- instrAddress  input  ADDRESS_WIDTH
- instrByteSelect  input  4
- instrEnable  input  1  (level request)
- instrWriteEnable  input  1
- instrDataWrite  input  32
- instrDataRead  output  32
- instrDone  output  1  (completion pulse)
- instrBusy  output  1
REQ-005 SHALL provide data port dataAddress, dataByteSelect, dataEnable, dataWriteEnable, dataDataWrite, dataDataRead, dataDone, dataBusy, with the same directions, widths and meanings as REQ-004.
REQ-006 SHALL provide downstream port:
- wbAddress  output  ADDRESS_WIDTH
- wbByteSelect  output  4
- wbEnable  output  1
- wbWriteEnable  output  1
- wbDataWrite  output  32
- wbDataRead  input  32
- wbBusy  input  1

Function
REQ-007 SHALL implement states IDLE, ISSUE and WAIT, plus a 1-bit grant register and a 1-bit lastGrant register.
REQ-008 IDLE: when any port enable is 1, SHALL grant that port and move to ISSUE.
- If both enables are 1, SHALL grant the port not equal to lastGrant (round-robin).
- On grant SHALL register wbAddress, wbByteSelect, wbWriteEnable and wbDataWrite from the granted port, and set lastGrant to the granted port.
REQ-009 ISSUE SHALL last exactly one cycle and ignore wbBusy; next state is WAIT.
REQ-010 WAIT: when wbBusy is 0, SHALL signal completion and return to IDLE next cycle; otherwise remain in WAIT.
REQ-011 wbEnable SHALL be combinational: granted port enable AND (ISSUE OR (WAIT AND wbBusy)).
- This forces wbEnable to 0 in the completion cycle, so the downstream stage does not start a second transaction.
REQ-012 Completion cycle: granted port xDone SHALL be 1 for exactly one cycle.
- xDataRead SHALL equal wbDataRead combinationally in that cycle.
- A per-port 32-bit register SHALL capture wbDataRead in that cycle and drive xDataRead at all other times.
- The other port's read register SHALL be unchanged.
REQ-013 xBusy SHALL equal xEnable AND NOT xDone.
REQ-014 Abort: if the granted port enable falls in ISSUE or WAIT, SHALL:
- drop wbEnable the same cycle;
- return to IDLE next cycle;
- emit no xDone and leave that port's read register unchanged.
REQ-015 A port enable still high after its xDone SHALL be treated as a new request in IDLE.
- Minimum spacing is 3 cycles between downstream transactions (IDLE, ISSUE, WAIT).
REQ-016 Latency: request in IDLE at cycle N gives wbEnable = 1 at N+1; the earliest xDone is at N+2.
REQ-017 Downstream error termination appears as wbBusy = 0. It SHALL be completed per REQ-012, with data passed through unchanged (0xFFFFFFFF from the downstream stage).
REQ-018 Write transactions SHALL complete identically to reads; the read register SHALL still capture wbDataRead.

Reset
REQ-019 While wb_rst_i = 1, SHALL hold:
- state IDLE, lastGrant = instruction (so data wins the first tie);
- wbEnable 0, wbAddress 0, wbByteSelect 0, wbWriteEnable 0, wbDataWrite 0xFFFFFFFF;
- both read registers 0xFFFFFFFF, both xDone 0.
REQ-020 Reset asserted mid-transaction SHALL drop wbEnable immediately and emit no xDone.

Verification
REQ-021 Single read: dataEnable = 1, dataAddress 0x0000100 at cycle 0; wbBusy 0 at cycle 1, 1 at cycles 2-4, 0 at cycle 5 with wbDataRead 0x12345678 -> wbEnable 1 at cycles 1-4 and 0 at cycle 5; dataDone 1 only at cycle 5; dataDataRead = 0x12345678 from cycle 5 on.
REQ-022 Tie after reset: both enables rise at the same cycle -> data granted first; instruction granted at the IDLE after data completes; wbAddress follows each grant.
REQ-023 Round-robin: both ports held requesting for 4 transactions -> grant order data, instr, data, instr.
REQ-024 Abort: instrEnable drops at the cycle after ISSUE -> wbEnable 0 that cycle; no instrDone; instrDataRead keeps its prior value; IDLE next cycle.
REQ-025 Error: wbBusy returns 0 with wbDataRead 0xFFFFFFFF -> xDone pulses once and xDataRead = 0xFFFFFFFF.
REQ-026 Async reset in WAIT: wb_rst_i pulses mid-cycle -> wbEnable 0 before the next edge; all REQ-019 values hold; no xDone.
